cic_decimator: RTL and testbench

- Multi-stage CIC decimator (Hogenauer, differential delay 1), placed directly downstream of the IIR notch stage in the DFE filter array.
- Consumes the notch output samples, qualified by the notch valid_out, and produces one sample per DEC_FACTOR accepted inputs.
- The output is gain-shifted, rounded and saturated back to the Q1.15 data format.
- Overflow and underflow flags are aligned with each output sample.

---
 rtl/dfe_pkg.sv | 60 ++++++
 rtl/cic_comb_stage.sv | 32 +++
 rtl/cic_decimator.sv | 137 +++++++++++++
 tb/tb_cic_decimator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfe_pkg.sv
// Shared definitions for the DFE filter array.
//   cic_growth  - CIC bit growth, ceil(log2(R**N)).
//   Q15_MAX/MIN - Q1.15 saturation limits.
//   round_sat   - round half up after an arithmetic right shift, then
//                 saturate to a signed width; flags report saturation.
package dfe_pkg;

    localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;

    function automatic int cic_growth(input int r, input int n);
        longint unsigned p;
        int              g;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * longint'(r);
        end
        g = 0;
        for (int unsigned b = 0; b < 63; b++) begin
            if ((64'd1 << b) < p) begin
                g = int'(b) + 1;
            end
        end
        return g;
    endfunction

    // Returns the saturated value sign-extended to 64 bits; callers keep
    // the low `width` bits.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] val,
        input  int                 shift,
        input  int                 width,
        output logic               ovf,
        output logic               unf
    );
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] res;
        if (shift > 0) begin
            s = (val + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            s = val;
        end
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        ovf   = 1'b0;
        unf   = 1'b0;
        res   = s;
        if (s > max_v) begin
            res = max_v;
            ovf = 1'b1;
        end else if (s < min_v) begin
            res = min_v;
            unf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section (differential delay 1).
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - decimation strobe: capture din into the delay register
//   clr        - synchronous clear of the delay register
//   din        - stage input (wrapping two's complement)
//   dout       - din minus the delayed value, combinational
module cic_comb_stage #(
    parameter int WIDTH = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] dout
);

    logic signed [WIDTH-1:0] dly;

    assign dout = din - dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else if (clr) begin
            dly <= '0;
        end else if (en) begin
            dly <= din;
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator by DEC_FACTOR with gain shift, rounding and
// saturation back to DATA_WIDTH.
//   clk, rst_n - clock, asynchronous active-low reset
//   valid_in   - input sample strobe (arbitrary gaps)
//   bypass     - registered pass-through, filter state held at zero
//   sync_clr   - synchronous clear of all filter state
//   cic_in     - signed input sample
//   cic_out    - signed output sample, registered
//   valid_out  - one-cycle pulse per new cic_out
//   overflow   - positive saturation on this output
//   underflow  - negative saturation on this output
module cic_decimator
    import dfe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEC_FACTOR = 5,
    parameter int N_STAGES   = 5,
    parameter int GAIN_SHIFT = cic_growth(DEC_FACTOR, N_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  bypass,
    input  logic                  sync_clr,
    input  logic [DATA_WIDTH-1:0] cic_in,
    output logic [DATA_WIDTH-1:0] cic_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int GROWTH    = cic_growth(DEC_FACTOR, N_STAGES);
    localparam int ACC_WIDTH = DATA_WIDTH + GROWTH;
    localparam int CNT_W     = $clog2(DEC_FACTOR);

    logic                        hold_clr;
    logic                        accept;
    logic                        dec_evt;
    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_WIDTH-1:0] in_ext;
    logic signed [ACC_WIDTH-1:0] r;
    logic signed [63:0]          r_ext;
    logic [DATA_WIDTH-1:0]       sat_val;
    logic                        sat_ovf;
    logic                        sat_unf;

    assign hold_clr = sync_clr | bypass;
    assign accept   = valid_in & ~hold_clr;
    assign dec_evt  = accept & (cnt == CNT_W'(DEC_FACTOR - 1));
    assign in_ext   = {{GROWTH{cic_in[DATA_WIDTH-1]}}, cic_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (hold_clr) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= dec_evt ? '0 : cnt + 1'b1;
        end
    end

    // Each integrator adds the previous stage's registered value, so the
    // chain is a pipeline; the comb input is likewise the pre-update value.
    for (genvar k = 0; k < N_STAGES; k++) begin : g_integ
        logic signed [ACC_WIDTH-1:0] acc;
        logic signed [ACC_WIDTH-1:0] addend;
        if (k == 0) begin : g_first
            assign addend = in_ext;
        end else begin : g_next
            assign addend = g_integ[k-1].acc;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (hold_clr) begin
                acc <= '0;
            end else if (accept) begin
                acc <= acc + addend;
            end
        end
    end

    for (genvar j = 0; j < N_STAGES; j++) begin : g_comb
        logic signed [ACC_WIDTH-1:0] cin;
        logic signed [ACC_WIDTH-1:0] cout;
        if (j == 0) begin : g_first
            assign cin = g_integ[N_STAGES-1].acc;
        end else begin : g_next
            assign cin = g_comb[j-1].cout;
        end
        cic_comb_stage #(
            .WIDTH(ACC_WIDTH)
        ) u_comb (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (dec_evt),
            .clr  (hold_clr),
            .din  (cin),
            .dout (cout)
        );
    end

    assign r     = g_comb[N_STAGES-1].cout;
    assign r_ext = {{(64 - ACC_WIDTH){r[ACC_WIDTH-1]}}, r};

    always_comb begin
        sat_ovf = 1'b0;
        sat_unf = 1'b0;
        sat_val = DATA_WIDTH'(round_sat(r_ext, GAIN_SHIFT, DATA_WIDTH, sat_ovf, sat_unf));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cic_out   <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sync_clr) begin
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bypass) begin
            cic_out   <= cic_in;
            valid_out <= valid_in;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid_out <= dec_evt;
            if (dec_evt) begin
                cic_out   <= sat_val;
                overflow  <= sat_ovf;
                underflow <= sat_unf;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: a default build (gain shift 12) and
// a reduced-shift build (gain shift 10) share one stimulus stream. The
// reference model is the equivalent FIR: taps of (1+z^-1+..+z^-(R-1))^N,
// delayed N samples, evaluated at every R-th accepted sample, wrapped to
// the accumulator width, then rounded and saturated.
module tb_cic_decimator;

    localparam int R    = 5;
    localparam int N    = 5;
    localparam int GS_A = 12;
    localparam int GS_B = 10;
    localparam int ACCW = 28;
    localparam int NT   = N * (R - 1) + 1;

    typedef struct {
        logic [15:0] d;
        logic        ovf;
        logic        unf;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        bypass = 1'b0;
    logic        sync_clr = 1'b0;
    logic [15:0] cic_in = '0;
    logic [15:0] a_out, b_out;
    logic        a_v, b_v, a_ov, b_ov, a_un, b_un;

    exp_t        qa[$];
    exp_t        qb[$];
    longint      hist[$];
    longint      h[NT];
    logic [15:0] log_a[$];
    longint      cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] last_a_d, last_b_d;
    logic        last_a_o, last_a_u, last_b_o, last_b_u;

    cic_decimator u_dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .bypass(bypass),
        .sync_clr(sync_clr), .cic_in(cic_in), .cic_out(a_out),
        .valid_out(a_v), .overflow(a_ov), .underflow(a_un)
    );

    cic_decimator #(
        .GAIN_SHIFT(GS_B)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .bypass(bypass),
        .sync_clr(sync_clr), .cic_in(cic_in), .cic_out(b_out),
        .valid_out(b_v), .overflow(b_ov), .underflow(b_un)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input longint r, input int gs);
        exp_t   e;
        longint s;
        s = (gs > 0) ? ((r + (longint'(1) <<< (gs - 1))) >>> gs) : r;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        e.due = cyc + 1;
        if (s > 32767) begin
            e.d = 16'h7FFF;
            e.ovf = 1'b1;
        end else if (s < -32768) begin
            e.d = 16'h8000;
            e.unf = 1'b1;
        end else begin
            e.d = s[15:0];
        end
        return e;
    endfunction

    function automatic longint fir(input int n);
        longint acc = 0;
        for (int i = 0; i < NT; i++) begin
            int idx = n - N - i;
            if (idx >= 0) acc += h[i] * hist[idx];
        end
        return (acc <<< (64 - ACCW)) >>> (64 - ACCW);
    endfunction

    task automatic model_step(input logic v, input logic [15:0] d, input logic byp, input logic clr);
        exp_t e;
        if (clr) begin
            hist.delete();
        end else if (byp) begin
            hist.delete();
            if (v) begin
                e.d = d; e.ovf = 1'b0; e.unf = 1'b0; e.due = cyc + 1;
                qa.push_back(e);
                qb.push_back(e);
            end
        end else if (v) begin
            hist.push_back(longint'($signed(d)));
            if (hist.size() % R == 0) begin
                longint r = fir(hist.size() - 1);
                qa.push_back(mk(r, GS_A));
                qb.push_back(mk(r, GS_B));
            end
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic byp, input logic clr);
        @(negedge clk);
        valid_in = v; cic_in = d; bypass = byp; sync_clr = clr;
        model_step(v, d, byp, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic dc(input logic [15:0] val, input int n);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        repeat (n) drive(1'b1, val, 1'b0, 1'b0);
        idle(3);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (a_v) begin
                if (qa.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_spurious: got valid_out=1 with data %0h expected no output", a_out);
                end else begin
                    e = qa.pop_front();
                    check("a_latency", cyc, e.due);
                    check("a_data", a_out, e.d);
                    check("a_ovf", a_ov, e.ovf);
                    check("a_unf", a_un, e.unf);
                end
                log_a.push_back(a_out);
                last_a_d = a_out; last_a_o = a_ov; last_a_u = a_un;
            end else if (qa.size() > 0 && qa[0].due < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL a_missing: got no valid_out expected data %0h", qa[0].d);
                void'(qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (b_v) begin
                if (qb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_spurious: got valid_out=1 with data %0h expected no output", b_out);
                end else begin
                    e = qb.pop_front();
                    check("b_latency", cyc, e.due);
                    check("b_data", b_out, e.d);
                    check("b_ovf", b_ov, e.ovf);
                    check("b_unf", b_un, e.unf);
                end
                last_b_d = b_out; last_b_o = b_ov; last_b_u = b_un;
            end else if (qb.size() > 0 && qb[0].due < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL b_missing: got no valid_out expected data %0h", qb[0].d);
                void'(qb.pop_front());
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_a_out"}, a_out, 16'h0);
        check({tag, "_a_valid"}, a_v, 1'b0);
        check({tag, "_a_flags"}, {a_ov, a_un}, 2'b00);
        check({tag, "_b_out"}, b_out, 16'h0);
        check({tag, "_b_valid"}, b_v, 1'b0);
        check({tag, "_b_flags"}, {b_ov, b_un}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] seq[50];
        logic [15:0] ung[$];
        longint      t[NT];

        for (int i = 0; i < NT; i++) h[i] = 0;
        h[0] = 1;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < NT; i++) t[i] = 0;
            for (int i = 0; i < NT; i++)
                for (int k = 0; k < R; k++)
                    if (i + k < NT) t[i + k] += h[i];
            h = t;
        end

        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        dc(16'h4000, 60);
        check("dc4000_a", {last_a_d, last_a_o, last_a_u}, {16'h30D4, 2'b00});
        check("dc4000_b", {last_b_d, last_b_o, last_b_u}, {16'h7FFF, 2'b10});
        dc(16'h7FFF, 60);
        check("dc7fff_a", {last_a_d, last_a_o, last_a_u}, {16'h61A7, 2'b00});
        dc(16'h8000, 60);
        check("dc8000_a", {last_a_d, last_a_o, last_a_u}, {16'h9E58, 2'b00});
        dc(16'hC000, 60);
        check("dcc000_b", {last_b_d, last_b_o, last_b_u}, {16'h8000, 2'b01});

        // bypass, then decimation restarting from a clean frame
        repeat (20) drive(1'($urandom), 16'($urandom), 1'b1, 1'b0);
        repeat (5) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
        idle(3);

        // sync_clr after 3 samples drops the partial frame and its own sample
        repeat (3) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
        drive(1'b1, 16'($urandom), 1'b0, 1'b1);
        repeat (5) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
        idle(3);

        // gapped and ungapped runs of one sequence give identical outputs
        for (int i = 0; i < 50; i++) seq[i] = 16'($urandom);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        log_a.delete();
        for (int i = 0; i < 50; i++) drive(1'b1, seq[i], 1'b0, 1'b0);
        idle(3);
        ung = log_a;
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        log_a.delete();
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, seq[i], 1'b0, 1'b0);
            idle(2);
        end
        idle(3);
        check("ungapped_count", ung.size(), 10);
        check("gapped_count", log_a.size(), 10);
        for (int i = 0; i < 10 && i < ung.size() && i < log_a.size(); i++)
            check("gap_vs_ungap", log_a[i], ung[i]);

        // full-scale random stress with random gaps; integrators wrap
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        repeat (6000) drive($urandom_range(0, 3) != 0, 16'($urandom), 1'b0, 1'b0);

        // asynchronous reset in the middle of a frame
        repeat (3) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        valid_in = 1'b0; bypass = 1'b0; sync_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        qa.delete(); qb.delete(); hist.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
        idle(4);

        check("a_pending", qa.size(), 0);
        check("b_pending", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
